div_unit: RTL and testbench

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. Sits in the execute stage directly upstream of the 32-bit, 8-way result-select mux and drives one of its data inputs. The hazard unit holds the pipeline while `busy` is high. `result` is held stable between operations, so the mux input never glitches while another source is selected.

---
 rtl/div_unit.sv | 138 +++++++++++++
 tb/tb_div_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional: DIV_FAST_SPECIAL_EN finishes /0 and overflow at accept.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      funct,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    FIN
  } state_t;

  state_t state, nxt;

  logic [4:0]  cnt;
  logic [31:0] dvd;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        is_rem;
  logic        neg_q;
  logic        neg_r;

  logic        acc;
  logic        sgn;
  logic        dz;
  logic [31:0] a1;
  logic [31:0] a2;
  logic [32:0] sh;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] qv;
  logic [31:0] rv;
  logic [31:0] fin;

`ifdef DIV_FAST_SPECIAL_EN
  logic        ovf;
  logic        special;
  logic [31:0] spec_res;
`endif

  assign sgn = ~funct[0];
  assign dz  = (rs2 == 32'h0);
  assign acc = start & ~kill & ((state == IDLE) | (state == FIN));
  assign a1  = (sgn & rs1[31]) ? (~rs1 + 32'd1) : rs1;
  assign a2  = (sgn & rs2[31]) ? (~rs2 + 32'd1) : rs2;

`ifdef DIV_FAST_SPECIAL_EN
  assign ovf = sgn & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
  assign special = dz | ovf;
  assign spec_res = funct[1] ? (dz ? rs1 : 32'h0)
                             : (dz ? 32'hFFFF_FFFF : 32'h8000_0000);
`endif

  // one restoring step: shift in next dividend bit, trial subtract
  assign sh   = {rem, dvd[31]};
  assign diff = sh - {1'b0, dvs};
  assign ge   = ~diff[32];

  // sign correction applied in FIX
  assign qv  = neg_q ? (~dvd + 32'd1) : dvd;
  assign rv  = neg_r ? (~rem + 32'd1) : rem;
  assign fin = is_rem ? rv : qv;

  assign busy = (state == RUN) | (state == FIX);
  assign done = (state == FIN);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state logic; kill overrides everything
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, FIN: begin
        if (acc) begin
`ifdef DIV_FAST_SPECIAL_EN
          nxt = special ? FIN : RUN;
`else
          nxt = RUN;
`endif
        end else if (state == FIN) begin
          nxt = IDLE;
        end
      end
      RUN: if (cnt == 5'd31) nxt = FIX;
      FIX: nxt = FIN;
      default: nxt = IDLE;
    endcase
    if (kill) nxt = IDLE;
  end

  // datapath: operand latch, iteration, result load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 5'd0;
      dvd    <= 32'h0;
      rem    <= 32'h0;
      dvs    <= 32'h0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (acc) begin
      cnt    <= 5'd0;
      dvd    <= a1;
      rem    <= 32'h0;
      dvs    <= a2;
      is_rem <= funct[1];
      neg_q  <= sgn & (rs1[31] ^ rs2[31]) & ~dz;
      neg_r  <= sgn & rs1[31];
`ifdef DIV_FAST_SPECIAL_EN
      if (special) result <= spec_res;
`endif
    end else if (state == RUN) begin
      rem <= ge ? diff[31:0] : sh[31:0];
      dvd <= {dvd[30:0], ge};
      cnt <= cnt + 5'd1;
    end else if ((state == FIX) && !kill) begin
      result <= fin;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit against an arithmetic model.
// Covers directed corner cases, kill, back-to-back and random ops.
module tb_div_unit;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [1:0]  funct = 0;
  logic [31:0] rs1 = 0;
  logic [31:0] rs2 = 0;
  logic        kill = 0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errs = 0;
  int checks = 0;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
    .rs1(rs1), .rs2(rs2), .kill(kill),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RV32M reference semantics
  function automatic logic [31:0] ref_op(input logic [1:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    int sa;
    int sb;
    logic ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      2'd0: if (b == 0) return 32'hFFFF_FFFF;
            else if (ovf) return 32'h8000_0000;
            else return sa / sb;
      2'd1: if (b == 0) return 32'hFFFF_FFFF;
            else return a / b;
      2'd2: if (b == 0) return a;
            else if (ovf) return 32'h0;
            else return sa % sb;
      default: if (b == 0) return a;
               else return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] f,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) ||
           (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic int exp_lat(input logic [1:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
    if (is_special(f, a, b)) return 1;
`endif
    return 34;
  endfunction

  // issue one op, wait for done, check latency, result, pulse width
  task automatic do_op(input string tag, input logic [1:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    int lat;
    bit got;
    int el;
    el = exp_lat(f, a, b);
    @(negedge clk);
    funct = f; rs1 = a; rs2 = b; start = 1;
    lat = 0;
    got = 0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      start = 0;
      if (lat == 1) chk({tag, " busy"}, busy, (el == 1) ? 0 : 1);
      if (done) got = 1;
    end
    chk({tag, " lat"}, lat, el);
    chk({tag, " res"}, result, ref_op(f, a, b));
    @(posedge clk);
    #1;
    chk({tag, " pulse"}, done, 0);
  endtask

  initial begin
    int lat;
    int ndone;
    bit got;
    logic [31:0] prev;
    logic [1:0] f;
    logic [31:0] a, b;

    #2;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    #20;
    @(negedge clk);
    rst_n = 1;

    do_op("divu 100/7", 2'd1, 100, 7);
    do_op("remu 100/7", 2'd3, 100, 7);
    do_op("div -100/7", 2'd0, 32'hFFFF_FF9C, 7);
    do_op("rem -100/7", 2'd2, 32'hFFFF_FF9C, 7);
    do_op("div 5/0", 2'd0, 5, 0);
    do_op("remu 5/0", 2'd3, 5, 0);
    do_op("div ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("div -7/0", 2'd0, 32'hFFFF_FFF9, 0);
    do_op("rem -7/0", 2'd2, 32'hFFFF_FFF9, 0);

    // kill 10 cycles after accept
    prev = result;
    @(negedge clk);
    funct = 2'd1; rs1 = 32'hFFFF_FFFF; rs2 = 3; start = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      start = 0;
    end
    chk("kill pre busy", busy, 1);
    kill = 1;
    @(posedge clk);
    #1;
    chk("kill busy", busy, 0);
    chk("kill done", done, 0);
    chk("kill result", result, prev);
    start = 1;
    @(posedge clk);
    #1;
    chk("kill+start busy", busy, 0);
    kill = 0;
    start = 0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("kill no done", ndone, 0);
    chk("kill result hold", result, prev);
    do_op("after kill", 2'd1, 1000, 10);

    // back-to-back with start pulses during RUN
    @(negedge clk);
    funct = 2'd1; rs1 = 9; rs2 = 3; start = 1;
    lat = 0;
    got = 0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      start = 0;
      if (done) got = 1;
    end
    chk("b2b first lat", lat, 34);
    chk("b2b first res", result, 3);
    funct = 2'd3; rs1 = 10; rs2 = 4; start = 1;
    lat = 0;
    got = 0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      start = 0;
      if (lat == 1) chk("b2b busy", busy, 1);
      if (lat == 5 || lat == 20) begin
        funct = 2'd0; rs1 = 77; rs2 = 2; start = 1;
      end
      if (done) got = 1;
    end
    start = 0;
    chk("b2b second lat", lat, 34);
    chk("b2b second res", result, 2);
    @(posedge clk);
    #1;
    chk("b2b pulse", done, 0);

    // random ops
    for (int i = 0; i < 24; i++) begin
      f = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i % 4 == 1) b = b >> $urandom_range(0, 31);
      do_op($sformatf("rnd%0d", i), f, a, b);
    end

    // asynchronous reset mid-operation
    @(negedge clk);
    funct = 2'd1; rs1 = 50; rs2 = 5; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst result", result, 0);
    @(negedge clk);
    rst_n = 1;
    do_op("after arst", 2'd3, 50, 7);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
